// File: rtl/mdu_pkg.sv
// Shared types and constants for the multi-cycle multiply/divide unit.
package mdu_pkg;

  localparam int MDU_WIDTH = 32;

  typedef enum logic [1:0] {
    MUL   = 2'b00,
    MULHU = 2'b01,
    UDIV  = 2'b10,
    UREM  = 2'b11
  } mdu_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } mdu_state_t;

endpackage

// File: rtl/mdu_step.sv
// One iteration of the datapath: right-shifting shift-add multiply, or
// left-shifting restoring divide, over a shared hi/lo register pair.
module mdu_step
  import mdu_pkg::*;
#(
  parameter int M = MDU_WIDTH
) (
  input  logic         is_div,
  input  logic [M-1:0] operand,
  input  logic [M-1:0] hi_in,
  input  logic [M-1:0] lo_in,
  output logic [M-1:0] hi_out,
  output logic [M-1:0] lo_out
);

  logic [M:0]   sum;
  logic [M:0]   rs;
  logic [M-1:0] diff;
  logic         ge;

  always_comb begin
    sum  = {1'b0, hi_in} + (lo_in[0] ? {1'b0, operand} : {(M+1){1'b0}});
    rs   = {hi_in, lo_in[M-1]};
    ge   = (rs >= {1'b0, operand});
    // When the subtraction succeeds the true difference is below the divisor,
    // so the low M bits of a modular subtract are exact.
    diff = rs[M-1:0] - operand;
    if (is_div) begin
      hi_out = ge ? diff : rs[M-1:0];
      lo_out = {lo_in[M-2:0], ge};
    end else begin
      hi_out = sum[M:1];
      lo_out = {sum[0], lo_in[M-1:1]};
    end
  end

endmodule

// File: rtl/mul_div_unit.sv
// Multi-cycle unsigned MUL/MULHU/UDIV/UREM unit: one bit per cycle, M cycles
// busy, then a single-cycle register-file write-back request.
module mul_div_unit
  import mdu_pkg::*;
#(
  parameter int M = MDU_WIDTH,
  parameter int N = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic [M-1:0] src_a,
  input  logic [M-1:0] src_b,
  input  logic [N-1:0] rd_in,
  output logic         busy,
  output logic         done,
  output logic         we,
  output logic [M-1:0] result,
  output logic [N-1:0] rd_out
);

  localparam int CW = $clog2(M) + 1;
  localparam logic [CW-1:0] LAST = CW'(M - 1);

  mdu_state_t    state;
  mdu_op_t       op_q;
  logic [CW-1:0] cnt;
  logic [M-1:0]  opnd;
  logic [M-1:0]  hi;
  logic [M-1:0]  lo;
  logic [M-1:0]  hi_nx;
  logic [M-1:0]  lo_nx;
  logic [N-1:0]  rd_q;
  logic          is_div;
  logic          accept;

  // Product lives in {hi, lo}; for division hi is the remainder, lo the quotient.
  function automatic logic [M-1:0] pick(input mdu_op_t o, input logic [M-1:0] h,
                                        input logic [M-1:0] l, input logic [M-1:0] d);
    case (o)
      MUL:     pick = l;
      MULHU:   pick = h;
      UDIV:    pick = (d == '0) ? '0 : l;
      default: pick = h;
    endcase
  endfunction

  assign is_div = (op_q == UDIV) || (op_q == UREM);
  assign busy   = (state == RUN);
  assign accept = start && ((state == IDLE) || (state == DONE));

  mdu_step #(.M(M)) u_step (
    .is_div  (is_div),
    .operand (opnd),
    .hi_in   (hi),
    .lo_in   (lo),
    .hi_out  (hi_nx),
    .lo_out  (lo_nx)
  );

  // Datapath registers carry no reset; the FSM decides when they matter.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_q <= mdu_op_t'(op);
      rd_q <= rd_in;
      hi   <= '0;
      if (op[1]) begin
        lo   <= src_a;
        opnd <= src_b;
      end else begin
        lo   <= src_b;
        opnd <= src_a;
      end
    end else if (state == RUN) begin
      hi <= hi_nx;
      lo <= lo_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      done   <= 1'b0;
      we     <= 1'b0;
      result <= '0;
      rd_out <= '0;
    end else begin
      done <= 1'b0;
      we   <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state <= RUN;
            cnt   <= '0;
          end
        end
        RUN: begin
          cnt <= cnt + CW'(1);
          if (cnt == LAST) begin
            state  <= DONE;
            done   <= 1'b1;
            we     <= 1'b1;
            result <= pick(op_q, hi_nx, lo_nx, opnd);
            rd_out <= rd_q;
          end
        end
        DONE: begin
          if (start) begin
            state <= RUN;
            cnt   <= '0;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: arithmetic, divide-by-zero, handshake,
// back-to-back issue and reset abort.
module tb_mul_div_unit;
  import mdu_pkg::*;

  localparam int M = 32;
  localparam int N = 6;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [1:0]   op = 2'b00;
  logic [M-1:0] src_a = '0;
  logic [M-1:0] src_b = '0;
  logic [N-1:0] rd_in = '0;
  logic         busy, done, we;
  logic [M-1:0] result;
  logic [N-1:0] rd_out;

  int tests = 0;
  int fails = 0;

  mul_div_unit #(.M(M), .N(N)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
    .rd_in(rd_in), .busy(busy), .done(done), .we(we), .result(result), .rd_out(rd_out)
  );

  always #5 clk = ~clk;

  // Drives one start pulse; returns #1 after the accepting edge.
  task automatic issue(input logic [1:0] o, input logic [M-1:0] a, input logic [M-1:0] b,
                       input logic [N-1:0] r);
    @(posedge clk); #1;
    op = o; src_a = a; src_b = b; rd_in = r; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Waits (bounded) for done; returns #1 after the edge that raised it.
  task automatic wait_done(output logic [M-1:0] res, output logic [N-1:0] rdo,
                           output logic we_s, output int lat, output int bcnt, output bit ok);
    lat = 0; bcnt = busy ? 1 : 0; ok = 1'b0; res = '0; rdo = '0; we_s = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      lat++;
      if (done) begin
        ok = 1'b1; res = result; rdo = rd_out; we_s = we;
        break;
      end
      if (busy) bcnt++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
    tests++; if (done !== 1'b0 || we !== 1'b0) begin fails++; $display("FAIL reset_done_we got %b%b want 00", done, we); end
    tests++; if (result !== '0 || rd_out !== '0) begin fails++; $display("FAIL reset_data got %h/%0d want 0/0", result, rd_out); end
    rst = 1'b0;
  endtask

  task automatic test_mul();
    logic [M-1:0] r; logic [N-1:0] d; logic w; int lat, bc; bit ok;
    issue(2'b00, 32'd7, 32'd6, 6'd3);
    wait_done(r, d, w, lat, bc, ok);
    tests++; if (!ok || r !== 32'd42) begin fails++; $display("FAIL mul_7x6 got %0d ok=%0d want 42", r, ok); end
    tests++; if (d !== 6'd3 || w !== 1'b1) begin fails++; $display("FAIL mul_rd_we got rd=%0d we=%b want 3/1", d, w); end
    tests++; if (lat != M || bc != M) begin fails++; $display("FAIL mul_latency got lat=%0d busy=%0d want %0d/%0d", lat, bc, M, M); end
    @(posedge clk); #1;
    tests++; if (we !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL mul_after got we=%b done=%b busy=%b want 000", we, done, busy); end
    tests++; if (result !== 32'd42 || rd_out !== 6'd3) begin fails++; $display("FAIL mul_hold got %0d/%0d want 42/3", result, rd_out); end
  endtask

  task automatic test_mulhu();
    logic [M-1:0] r; logic [N-1:0] d; logic w; int lat, bc; bit ok;
    issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'd10);
    wait_done(r, d, w, lat, bc, ok);
    tests++; if (!ok || r !== 32'hFFFF_FFFE) begin fails++; $display("FAIL mulhu_max got %h want fffffffe", r); end
    issue(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'd11);
    wait_done(r, d, w, lat, bc, ok);
    tests++; if (!ok || r !== 32'h0000_0001) begin fails++; $display("FAIL mul_max got %h want 00000001", r); end
  endtask

  task automatic test_div();
    logic [M-1:0] r; logic [N-1:0] d; logic w; int lat, bc; bit ok;
    issue(2'b10, 32'd100, 32'd7, 6'd12);
    wait_done(r, d, w, lat, bc, ok);
    tests++; if (!ok || r !== 32'd14 || d !== 6'd12) begin fails++; $display("FAIL udiv_100_7 got %0d rd=%0d want 14/12", r, d); end
    issue(2'b11, 32'd100, 32'd7, 6'd13);
    wait_done(r, d, w, lat, bc, ok);
    tests++; if (!ok || r !== 32'd2) begin fails++; $display("FAIL urem_100_7 got %0d want 2", r); end
    issue(2'b10, 32'hFFFF_FFFF, 32'd1, 6'd14);
    wait_done(r, d, w, lat, bc, ok);
    tests++; if (!ok || r !== 32'hFFFF_FFFF) begin fails++; $display("FAIL udiv_max_1 got %h want ffffffff", r); end
  endtask

  task automatic test_div_zero();
    logic [M-1:0] r; logic [N-1:0] d; logic w; int lat, bc; bit ok;
    issue(2'b10, 32'd55, 32'd0, 6'd20);
    wait_done(r, d, w, lat, bc, ok);
    tests++; if (!ok || r !== 32'd0) begin fails++; $display("FAIL udiv_by_zero got %0d want 0", r); end
    tests++; if (lat != M) begin fails++; $display("FAIL udiv_by_zero_lat got %0d want %0d", lat, M); end
    issue(2'b11, 32'd55, 32'd0, 6'd21);
    wait_done(r, d, w, lat, bc, ok);
    tests++; if (!ok || r !== 32'd55) begin fails++; $display("FAIL urem_by_zero got %0d want 55", r); end
    tests++; if (lat != M) begin fails++; $display("FAIL urem_by_zero_lat got %0d want %0d", lat, M); end
  endtask

  task automatic test_ignore_start();
    logic [M-1:0] r; logic [N-1:0] d; logic w; int lat, bc; bit ok;
    issue(2'b00, 32'd10, 32'd10, 6'd4);
    repeat (5) @(posedge clk);
    #1;
    op = 2'b00; src_a = 32'd3; src_b = 32'd3; rd_in = 6'd9; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(r, d, w, lat, bc, ok);
    tests++; if (!ok || r !== 32'd100 || d !== 6'd4) begin fails++; $display("FAIL ignore_start got %0d rd=%0d want 100/4", r, d); end
    @(posedge clk); #1;
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL ignore_start_idle got busy=%b want 0", busy); end
  endtask

  task automatic test_back_to_back();
    logic [M-1:0] r; logic [N-1:0] d; logic w; int lat, bc; bit ok;
    issue(2'b00, 32'd5, 32'd5, 6'd1);
    wait_done(r, d, w, lat, bc, ok);
    tests++; if (!ok || r !== 32'd25) begin fails++; $display("FAIL b2b_first got %0d want 25", r); end
    op = 2'b10; src_a = 32'd9; src_b = 32'd2; rd_in = 6'd2; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL b2b_restart got busy=%b want 1", busy); end
    wait_done(r, d, w, lat, bc, ok);
    tests++; if (!ok || r !== 32'd4 || d !== 6'd2) begin fails++; $display("FAIL b2b_udiv_9_2 got %0d rd=%0d want 4/2", r, d); end
    tests++; if (lat + 1 != M + 1) begin fails++; $display("FAIL b2b_period got %0d want %0d", lat + 1, M + 1); end
  endtask

  task automatic test_reset_mid();
    logic [M-1:0] r; logic [N-1:0] d; logic w; int lat, bc; bit ok; bit seen;
    issue(2'b00, 32'd12, 32'd12, 6'd7);
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    tests++; if (busy !== 1'b0 || done !== 1'b0 || we !== 1'b0) begin fails++; $display("FAIL rst_mid got busy=%b done=%b we=%b want 000", busy, done, we); end
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done || we) seen = 1'b1;
    end
    tests++; if (seen) begin fails++; $display("FAIL rst_mid_no_write got pulse=1 want 0"); end
    issue(2'b00, 32'd2, 32'd5, 6'd5);
    wait_done(r, d, w, lat, bc, ok);
    tests++; if (!ok || r !== 32'd10 || d !== 6'd5) begin fails++; $display("FAIL rst_mid_fresh got %0d rd=%0d want 10/5", r, d); end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_mulhu();
    test_div();
    test_div_zero();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
